// File: rtl/if_pkg.sv
// Shared fetch-stage types: the fetch-entry record and the NOP used for faulted fetches.
package if_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    // Entry PC is carried at the widest supported XLEN; narrower units zero-extend.
    localparam int unsigned PC_MAX_W = 64;

    typedef struct packed {
        logic [PC_MAX_W-1:0] pc;
        logic [31:0]         instr;
        logic                fault;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// Prefetch buffer: power-of-2 ring with flush, combinational head, push allowed on a full pop.
module if_fetch_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign do_pop  = pop && (count != '0);
    // When full, the slot being pushed is the one the pop frees this cycle.
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: PC sequencer, local instruction memory and a prefetch buffer toward decode.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int unsigned     XLEN       = 32,
    parameter int unsigned     IMEM_DEPTH = 64,
    parameter int unsigned     BUF_DEPTH  = 2,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          redirect_valid,
    input  logic [XLEN-1:0]               redirect_pc,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [XLEN-1:0]               out_pc,
    output logic [31:0]                   out_instr,
    output logic                          out_fault,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [31:0]                   imem_wdata
);
    localparam int unsigned AW = $clog2(IMEM_DEPTH);
    localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

    // Power-on contents only; reset deliberately leaves the program intact.
    logic [31:0] imem [IMEM_DEPTH] = '{default: NOP_INSTR};

    logic [XLEN-1:0] fetch_pc;
    logic            fetch_fault;
    logic [31:0]     fetch_instr;
    logic            enq, deq;
    logic [CW-1:0]   count;
    fetch_entry_t    enq_entry, head_entry;

    always_ff @(posedge clk) begin
        if (imem_we) imem[imem_waddr] <= imem_wdata;
    end

    assign fetch_fault = (fetch_pc[1:0] != 2'b00) || (fetch_pc >= XLEN'(4 * IMEM_DEPTH));
    assign fetch_instr = fetch_fault ? NOP_INSTR : imem[fetch_pc[AW+1:2]];

    assign deq = out_valid && out_ready;
    assign enq = !redirect_valid && ((count != CW'(BUF_DEPTH)) || deq);

    assign enq_entry = '{pc: PC_MAX_W'(fetch_pc), instr: fetch_instr, fault: fetch_fault};

    always_ff @(posedge clk or posedge reset) begin
        if (reset)               fetch_pc <= RESET_PC;
        else if (redirect_valid) fetch_pc <= redirect_pc;
        else if (enq)            fetch_pc <= fetch_pc + XLEN'(4);
    end

    if_fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (enq),
        .push_data (enq_entry),
        .pop       (deq),
        .head      (head_entry),
        .count     (count)
    );

    // Zero the head fields whenever empty so reset shows all-zero outputs at once.
    assign out_valid = (count != '0);
    assign out_pc    = out_valid ? XLEN'(head_entry.pc) : '0;
    assign out_instr = out_valid ? head_entry.instr     : '0;
    assign out_fault = out_valid && head_entry.fault;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: streaming, backpressure, redirect, faults, imem write, reset.
module tb_if_fetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_fault;
    logic        imem_we;
    logic [5:0]  imem_waddr;
    logic [31:0] imem_wdata;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] W8  = 32'h00A0_0513;
    localparam logic [31:0] OLD3 = 32'h0030_8193;
    localparam logic [31:0] NEW3 = 32'h0050_0293;
    logic [31:0] words [5] = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113, 32'h0030_8193, 32'h0041_0213};

    if_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_ready      (out_ready),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_fault      (out_fault),
        .imem_we        (imem_we),
        .imem_waddr     (imem_waddr),
        .imem_wdata     (imem_wdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        out_ready = 1'b1; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0 || out_fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b pc=%h instr=%h fault=%b, want all zero",
                     out_valid, out_pc, out_instr, out_fault);
        end
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            imem_we = 1'b1; imem_waddr = 6'(i); imem_wdata = words[i];
            step();
        end
        imem_we = 1'b1; imem_waddr = 6'd8; imem_wdata = W8;
        step();
        imem_we = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_stream();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * i) || out_instr !== words[i] || out_fault !== 1'b0) begin
                errors++;
                $display("FAIL stream[%0d]: valid=%b pc=%h instr=%h fault=%b, want 1 %h %h 0",
                         i, out_valid, out_pc, out_instr, out_fault, 32'(4 * i), words[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        reset = 1'b1; out_ready = 1'b0;
        step();
        reset = 1'b0;
        repeat (5) step();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || dut.u_fifo.count !== 2'd2 || dut.fetch_pc !== 32'h8) begin
            errors++;
            $display("FAIL backpressure_hold: valid=%b pc=%h count=%0d fetch_pc=%h, want 1 0 2 8",
                     out_valid, out_pc, dut.u_fifo.count, dut.fetch_pc);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * i) || out_instr !== words[i]) begin
                errors++;
                $display("FAIL backpressure_drain[%0d]: valid=%b pc=%h instr=%h, want 1 %h %h",
                         i, out_valid, out_pc, out_instr, 32'(4 * i), words[i]);
            end
            step();
        end
    endtask

    task automatic test_redirect();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL redirect_pre: out_valid=%b, want 1", out_valid);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h20;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_bubble: out_valid=%b, want 0", out_valid);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h20 || out_instr !== W8 || out_fault !== 1'b0) begin
            errors++;
            $display("FAIL redirect_target: valid=%b pc=%h instr=%h fault=%b, want 1 20 %h 0",
                     out_valid, out_pc, out_instr, out_fault, W8);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h24 || out_instr !== NOP) begin
            errors++;
            $display("FAIL redirect_next: valid=%b pc=%h instr=%h, want 1 24 %h", out_valid, out_pc, out_instr, NOP);
        end
    endtask

    task automatic test_fault();
        redirect_valid = 1'b1; redirect_pc = 32'h22;
        step();
        redirect_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h22 || out_fault !== 1'b1 || out_instr !== NOP) begin
            errors++;
            $display("FAIL fault_misaligned: valid=%b pc=%h fault=%b instr=%h, want 1 22 1 %h",
                     out_valid, out_pc, out_fault, out_instr, NOP);
        end
        step();
        checks++;
        if (out_pc !== 32'h26 || out_fault !== 1'b1) begin
            errors++;
            $display("FAIL fault_misaligned_next: pc=%h fault=%b, want 26 1", out_pc, out_fault);
        end
        redirect_valid = 1'b1; redirect_pc = 32'd252;
        step();
        redirect_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'd252 || out_fault !== 1'b0 || out_instr !== NOP) begin
            errors++;
            $display("FAIL fault_last_word: valid=%b pc=%h fault=%b instr=%h, want 1 fc 0 %h",
                     out_valid, out_pc, out_fault, out_instr, NOP);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'd256 || out_fault !== 1'b1 || out_instr !== NOP) begin
            errors++;
            $display("FAIL fault_out_of_range: valid=%b pc=%h fault=%b instr=%h, want 1 100 1 %h",
                     out_valid, out_pc, out_fault, out_instr, NOP);
        end
    endtask

    task automatic test_imem_write();
        redirect_valid = 1'b1; redirect_pc = 32'd12;
        step();
        redirect_valid = 1'b0;
        imem_we = 1'b1; imem_waddr = 6'd3; imem_wdata = NEW3;
        step();
        imem_we = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'd12 || out_instr !== OLD3) begin
            errors++;
            $display("FAIL imem_old_data: valid=%b pc=%h instr=%h, want 1 c %h", out_valid, out_pc, out_instr, OLD3);
        end
        redirect_valid = 1'b1; redirect_pc = 32'd12;
        step();
        redirect_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'd12 || out_instr !== NEW3) begin
            errors++;
            $display("FAIL imem_new_data: valid=%b pc=%h instr=%h, want 1 c %h", out_valid, out_pc, out_instr, NEW3);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        step();
        redirect_valid = 1'b0;
        repeat (3) step();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h40 || dut.u_fifo.count !== 2'd2) begin
            errors++;
            $display("FAIL reset_mid_pre: valid=%b pc=%h count=%0d, want 1 40 2", out_valid, out_pc, dut.u_fifo.count);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0 || out_fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async: valid=%b pc=%h instr=%h fault=%b, want all zero",
                     out_valid, out_pc, out_instr, out_fault);
        end
        @(negedge clk);
        reset = 1'b0; out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== words[0]) begin
            errors++;
            $display("FAIL reset_mid_restart: valid=%b pc=%h instr=%h, want 1 0 %h", out_valid, out_pc, out_instr, words[0]);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h4 || out_instr !== words[1]) begin
            errors++;
            $display("FAIL reset_mid_second: valid=%b pc=%h instr=%h, want 1 4 %h", out_valid, out_pc, out_instr, words[1]);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_fault();
        test_imem_write();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and PC width.
REQ-002 SHALL have parameter IMEM_DEPTH, default 64, instruction-memory words, power of 2, at least 4.
REQ-003 SHALL have parameter BUF_DEPTH, default 2, prefetch-buffer entries, power of 2, at least 2.
REQ-004 SHALL have parameter RESET_PC, default 0, PC after reset.
REQ-005 SHALL have these ports: clk  in  1  clock, rising edge.
REQ-006 SHALL have: reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have: redirect_valid  in  1  branch/jump redirect request.
REQ-008 SHALL have: redirect_pc  in  XLEN  redirect target.
REQ-009 SHALL have: out_ready  in  1  decode can accept.
REQ-010 SHALL have: out_valid  out  1  head entry valid.
REQ-011 SHALL have: out_pc  out  XLEN  PC of head entry.
REQ-012 SHALL have: out_instr  out  32  instruction of head entry.
REQ-013 SHALL have: out_fault  out  1  head entry is a fetch fault.
REQ-014 SHALL have: imem_we  in  1  program-load write enable.
REQ-015 SHALL have: imem_waddr  in  log2(IMEM_DEPTH)  word address for the write.
REQ-016 SHALL have: imem_wdata  in  32  write data.

Function
REQ-017 SHALL hold fetch_pc, fetch from imem[fetch_pc[log2(IMEM_DEPTH)+1:2]] combinationally, and enqueue {fetch_pc, instr, fault} at the clock edge.
REQ-018 SHALL enqueue when count<BUF_DEPTH, or when count==BUF_DEPTH and a dequeue occurs in the same cycle, and redirect_valid is 0; fetch_pc += 4 on each enqueue, wrapping mod 2^XLEN.
REQ-019 SHALL dequeue the head when out_valid && out_ready; out_* SHALL be driven from the buffer head, with out_valid = (count != 0).
REQ-020 SHALL set fault = (fetch_pc[1:0] != 0) || (fetch_pc >= 4*IMEM_DEPTH); a faulted entry SHALL carry instr 32'h00000013 (NOP).
REQ-021 SHALL handle redirect_valid as follows: flush all buffer entries, set fetch_pc <= redirect_pc, and make no enqueue that cycle; out_valid is 0 next cycle; the first target entry is valid 2 cycles after the redirect edge.
REQ-022 SHALL give redirect priority over a simultaneous dequeue or enqueue; the head presented in the redirect cycle is discarded even if out_ready=1.
REQ-023 SHALL write imem[imem_waddr] <= imem_wdata on imem_we; a fetch of the same word in the same cycle SHALL see the old data.
REQ-024 SHALL keep out_pc, out_instr, and out_fault stable while out_valid && !out_ready.
REQ-025 SHALL have a first-entry latency after reset release of 1 cycle: the entry for RESET_PC is valid after the first rising edge with reset low.
REQ-026 SHALL initialise imem to all NOP at time zero; imem contents SHALL NOT be altered by reset.

Reset
REQ-027 SHALL, on reset (asynchronous), set fetch_pc=RESET_PC, count=0, out_valid=0, out_pc=0, out_instr=0, out_fault=0, and clear the buffer pointers.
REQ-028 SHALL treat reset asserted mid-stream as a flush: no entry is retained, and fetching restarts at RESET_PC.

Structure
REQ-029 SHALL place the NOP constant (32'h00000013) and the fetch-entry struct {pc, instr, fault} in shared package if_pkg.
REQ-030 SHALL implement the prefetch buffer as sub-module if_fetch_fifo (parametrised width/depth, flush input, simultaneous push/pop when full).

Verification
REQ-031 SHALL cover: imem[0..4] = 0x13, 0x00100093, 0x00200113, 0x00308193, 0x00410213, reset release, out_ready=1 -> pcs 0, 4, 8, 12, 16 with those words, one per cycle.
REQ-032 SHALL cover: out_ready=0 for 5 cycles -> count saturates at 2, head stays at pc 0, fetch_pc stays at 8; release -> 0, 4, 8 in order, with no gap or duplicate.
REQ-033 SHALL cover: redirect_valid with redirect_pc=0x20 while out_valid -> out_valid=0 the next cycle, then pc 0x20 with imem[8], and no stale entries.
REQ-034 SHALL cover: redirect_pc=0x22 -> entry pc 0x22, out_fault=1, instr 0x13; redirect to 4*IMEM_DEPTH -> out_fault=1.
REQ-035 SHALL cover: imem_we at waddr 3 in the same cycle that pc 12 is fetched -> old word delivered; refetch after redirect to 12 -> new word.
REQ-036 SHALL cover: reset pulse mid-stream with count=2 -> outputs 0 immediately, then a restart at RESET_PC.
